// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit and the forwarding logic:
// FSM state encodings, the hard-wired zero register and a source-match helper.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hcu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_mem_wait_timer.sv
// Data-memory wait-state counter: 8-bit, saturating at MEM_TIMEOUT, with a
// look-ahead flag that fires in the wait cycle whose closing edge reaches the limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ready,
  output logic [7:0] count,
  output logic       expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (start) begin
      count_reg <= 8'd1;
    end else if (count_reg != 8'd0) begin
      if (ready) begin
        count_reg <= 8'd0;
      end else if (count_reg != LIMIT) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  assign count   = count_reg;
  assign expired = (count_reg != 8'd0) && !ready && ((count_reg + 8'd1) == LIMIT);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stall, branch flush, data-memory
// freeze with timeout. Define STALL_COUNT_EN to add the stall_cycles counter port.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_MemRead,
  input  logic        EX_branch_taken,
  input  logic        EX_Mem_MemAccess,
  input  logic        dmem_ready,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Flush,
  output logic        EX_Mem_Write,
  output logic        Mem_WB_Flush,
  output logic        mem_error
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  hcu_state_t state_reg;
  logic       mem_error_reg;
  logic [7:0] wait_count;
  logic       wait_expired;
  logic       timer_start;
  logic       mem_stall;
  logic       load_use;
  logic [1:0] src_hit;
  logic [4:0] id_src [2];

  assign id_src[0] = IF_ID_rs1;
  assign id_src[1] = IF_ID_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_match(ID_EX_rd, id_src[gi]);
    end
  endgenerate

  assign load_use = ID_EX_MemRead && (|src_hit);

  // A new access only starts counting from an idle timer
  assign timer_start = (state_reg == RUN) && EX_Mem_MemAccess && !dmem_ready
                       && (wait_count == 8'd0);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .ready   (dmem_ready),
    .count   (wait_count),
    .expired (wait_expired)
  );

  always_comb begin
    mem_stall = 1'b0;
    case (state_reg)
      RUN:      mem_stall = EX_Mem_MemAccess && !dmem_ready;
      MEM_WAIT: mem_stall = !dmem_ready;
      default:  mem_stall = 1'b1;
    endcase
  end

  // Freeze outranks branch flush, which outranks the load-use stall
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_Mem_Write = 1'b1;
    Mem_WB_Flush = 1'b0;
    if (mem_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_Mem_Write = 1'b0;
      Mem_WB_Flush = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RUN;
      mem_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (EX_Mem_MemAccess && !dmem_ready) state_reg <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_reg <= RUN;
          end else if (wait_expired) begin
            state_reg     <= ERROR;
            mem_error_reg <= 1'b1;
          end
        end
        ERROR: begin
          state_reg     <= ERROR;
          mem_error_reg <= 1'b1;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign mem_error = mem_error_reg;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= 32'd0;
    end else if (!PC_Write && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: per-cycle comparison against a
// behavioural model plus directed literal expectations.
module tb_hazard_control_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  IF_ID_rs1 = 5'd0;
  logic [4:0]  IF_ID_rs2 = 5'd0;
  logic [4:0]  ID_EX_rd = 5'd0;
  logic        ID_EX_MemRead = 1'b0;
  logic        EX_branch_taken = 1'b0;
  logic        EX_Mem_MemAccess = 1'b0;
  logic        dmem_ready = 1'b1;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic        EX_Mem_Write, Mem_WB_Flush, mem_error;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .IF_ID_rs1        (IF_ID_rs1),
    .IF_ID_rs2        (IF_ID_rs2),
    .ID_EX_rd         (ID_EX_rd),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .EX_branch_taken  (EX_branch_taken),
    .EX_Mem_MemAccess (EX_Mem_MemAccess),
    .dmem_ready       (dmem_ready),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Write      (ID_EX_Write),
    .ID_EX_Flush      (ID_EX_Flush),
    .EX_Mem_Write     (EX_Mem_Write),
    .Mem_WB_Flush     (Mem_WB_Flush),
    .mem_error        (mem_error)
`ifdef STALL_COUNT_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: wait-cycle tally of the current access, sticky error, stall tally
  bit          m_err = 1'b0;
  int          m_waits = 0;
  logic [31:0] m_stalls = 32'd0;

  typedef struct packed {
    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f;
  } ctl_t;

  function automatic bit mem_hold();
    return m_err || (!dmem_ready && (m_waits > 0 || EX_Mem_MemAccess));
  endfunction

  function automatic ctl_t expect_ctl();
    ctl_t c;
    bit   lu;
    c = '{pc_w: 1'b1, ifid_w: 1'b1, ifid_f: 1'b0, idex_w: 1'b1, idex_f: 1'b0,
          exmem_w: 1'b1, memwb_f: 1'b0};
    lu = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
         (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
    if (mem_hold()) begin
      c.pc_w = 1'b0; c.ifid_w = 1'b0; c.idex_w = 1'b0; c.exmem_w = 1'b0; c.memwb_f = 1'b1;
    end else if (EX_branch_taken) begin
      c.ifid_f = 1'b1; c.idex_f = 1'b1;
    end else if (lu) begin
      c.pc_w = 1'b0; c.ifid_w = 1'b0; c.idex_f = 1'b1;
    end
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    ctl_t c;
    if (reset) begin
      m_err    <= 1'b0;
      m_waits  <= 0;
      m_stalls <= 32'd0;
    end else begin
      c = expect_ctl();
      if (!c.pc_w && m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 32'd1;
      if (!m_err) begin
        if (mem_hold()) begin
          m_waits <= m_waits + 1;
          if (m_waits + 1 == TIMEOUT) m_err <= 1'b1;
        end else begin
          m_waits <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    ctl_t e;
    e = expect_ctl();
    chk("pc_write",     PC_Write,     e.pc_w);
    chk("if_id_write",  IF_ID_Write,  e.ifid_w);
    chk("if_id_flush",  IF_ID_Flush,  e.ifid_f);
    chk("id_ex_write",  ID_EX_Write,  e.idex_w);
    chk("id_ex_flush",  ID_EX_Flush,  e.idex_f);
    chk("ex_mem_write", EX_Mem_Write, e.exmem_w);
    chk("mem_wb_flush", Mem_WB_Flush, e.memwb_f);
    chk("mem_error",    mem_error,    m_err);
`ifdef STALL_COUNT_EN
    chk("stall_cycles", stall_cycles, m_stalls);
`endif
  end

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic acc, input logic rdy);
    IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; ID_EX_rd = rd;
    ID_EX_MemRead = mr; EX_branch_taken = br; EX_Mem_MemAccess = acc; dmem_ready = rdy;
  endtask

  task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic br, input logic acc, input logic rdy);
    @(posedge clk);
    #1;
    set_in(rs1, rs2, rd, mr, br, acc, rdy);
  endtask

  task automatic idle();
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #3;
    chk("rst_pc_write", PC_Write, 1'b1);
    chk("rst_mem_error", mem_error, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Load-use on rs2: one stall cycle, then the load has moved on
    cyc(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    chk("lu_pc_write", PC_Write, 1'b0);
    chk("lu_if_id_write", IF_ID_Write, 1'b0);
    chk("lu_id_ex_flush", ID_EX_Flush, 1'b1);
    chk("lu_ex_mem_write", EX_Mem_Write, 1'b1);
    cyc(5'd0, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    #3 chk("lu_after_pc_write", PC_Write, 1'b1);

    // Load targeting x0 never stalls
    cyc(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    chk("rd0_pc_write", PC_Write, 1'b1);
    chk("rd0_id_ex_flush", ID_EX_Flush, 1'b0);

    // Branch and matching load together: flush wins
    cyc(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    #3;
    chk("brlu_if_id_flush", IF_ID_Flush, 1'b1);
    chk("brlu_id_ex_flush", ID_EX_Flush, 1'b1);
    chk("brlu_pc_write", PC_Write, 1'b1);
    idle();

    // Three-cycle memory wait, release on the fourth
    for (int i = 0; i < 3; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      chk("mw_pc_write", PC_Write, 1'b0);
      chk("mw_mem_wb_flush", Mem_WB_Flush, 1'b1);
    end
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #3;
    chk("mw_rel_pc_write", PC_Write, 1'b1);
    chk("mw_rel_mem_wb_flush", Mem_WB_Flush, 1'b0);
    idle();
`ifdef STALL_COUNT_EN
    #3 chk("mw_stall_cycles", stall_cycles, 32'd4);
`endif

    // Branch held during a two-cycle freeze, flushed on release
    for (int i = 0; i < 2; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #3;
      chk("bf_if_id_flush", IF_ID_Flush, 1'b0);
      chk("bf_pc_write", PC_Write, 1'b0);
    end
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #3;
    chk("bf_rel_if_id_flush", IF_ID_Flush, 1'b1);
    chk("bf_rel_id_ex_flush", ID_EX_Flush, 1'b1);
    chk("bf_rel_pc_write", PC_Write, 1'b1);
    idle();

    // Timeout after four wait cycles, then a permanent freeze
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3 chk("to_wait_mem_error", mem_error, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      #3;
      chk("to_mem_error", mem_error, 1'b1);
      chk("to_pc_write", PC_Write, 1'b0);
      chk("to_ex_mem_write", EX_Mem_Write, 1'b0);
    end

    // Asynchronous reset out of ERROR
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_err_mem_error", mem_error, 1'b0);
    chk("rst_err_pc_write", PC_Write, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset in wait cycle 2, then a fresh three-cycle wait must not time out
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk("rmw_mem_error", mem_error, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #3 chk("rmw_wait_pc_write", PC_Write, 1'b0);
    end
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #3 chk("rmw_rel_pc_write", PC_Write, 1'b1);
    idle();
    #3 chk("rmw_no_error", mem_error, 1'b0);
    idle();

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
